// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer and its next-PC datapath.
// Both the sequencer FSM and the pipelined core import this package.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_HOLD,
    SEL_EXC
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int          WAIT_W           = 8;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake, execute-completion and PC status signals of the sequencer.
// The master modport is the sequencer; the slave side is imem plus the datapath.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic        imem_req;
  logic        imem_ack;
  logic        ir_load;
  logic        exec_done;
  logic        halt;
  logic        jump;
  logic [25:0] jump_index;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [31:0] pc;
  state_e      state;
  logic [31:0] retired;
  logic        timeout;

  modport master (
    output imem_req, ir_load, pc, state, retired, timeout,
    input  imem_ack, exec_done, halt, jump, jump_index, br_taken, br_offset
  );

  modport slave (
    input  imem_req, ir_load, pc, state, retired, timeout,
    output imem_ack, exec_done, halt, jump, jump_index, br_taken, br_offset
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selector: sequential, PC-relative branch, MIPS-style
// jump, hold, or exception vector. All arithmetic wraps modulo 2^32.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  pc_sel_e     i_sel,
  input  logic [31:0] i_br_offset,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_exc_vector,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_disp;

  assign w_pc4     = i_pc + 32'd4;
  assign w_br_disp = i_br_offset << 2;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // o_pc_next unassigned, which would otherwise infer a latch.
    o_pc_next = i_pc;
    case (i_sel)
      SEL_SEQ:    o_pc_next = w_pc4;
      SEL_BRANCH: o_pc_next = w_pc4 + w_br_disp;
      SEL_JUMP:   o_pc_next = {w_pc4[31:28], i_jump_index, 2'b00};
      SEL_EXC:    o_pc_next = i_exc_vector;
      default:    o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller owning the program counter: runs the
// imem handshake with a fetch timeout, then waits for exec_done to pick the next PC.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          MAX_WAIT     = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [31:0]         r_pc;
  logic [31:0]         w_pc_next;
  logic [31:0]         r_retired;
  logic                r_timeout;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  pc_sel_e             w_sel;
  logic                w_retire;
  logic                w_timeout_set;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_sel         = SEL_HOLD;
    w_retire      = 1'b0;
    w_wait_next   = r_wait;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RESET: w_state_next = ST_FETCH;
      ST_FETCH: begin
        // An ack in the threshold cycle takes precedence over the timeout.
        if (bus.imem_ack) begin
          w_state_next = ST_EXEC;
          w_wait_next  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_sel         = SEL_EXC;
          w_timeout_set = 1'b1;
          w_wait_next   = '0;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt) begin
            w_state_next = ST_HALTED;
          end else begin
            w_state_next = ST_FETCH;
            w_retire     = 1'b1;
            if (bus.jump)          w_sel = SEL_JUMP;
            else if (bus.br_taken) w_sel = SEL_BRANCH;
            else                   w_sel = SEL_SEQ;
          end
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    if (r_state == ST_FETCH) begin
      bus.imem_req = 1'b1;
      bus.ir_load  = bus.imem_ack;
    end
  end

  pc_next_calc u_pc_next_calc (
    .i_pc         (r_pc),
    .i_sel        (w_sel),
    .i_br_offset  (bus.br_offset),
    .i_jump_index (bus.jump_index),
    .i_exc_vector (EXC_VECTOR),
    .o_pc_next    (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_retired <= '0;
      r_timeout <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_pc   <= w_pc_next;
      r_wait <= w_wait_next;
      if (w_retire)      r_retired <= r_retired + 32'd1;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.state   = r_state;
  assign bus.retired = r_retired;
  assign bus.timeout = r_timeout;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute controller that owns the program counter for the CPU core.
- Runs the instruction-memory fetch handshake and waits for the datapath to finish each instruction.
- Selects the next PC: sequential, PC-relative branch, absolute jump, halt, or fetch-timeout exception vector.
- Sits between instruction memory, the instruction register load and the execute datapath.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded on fetch timeout
MAX_WAIT, 15, FETCH cycles without imem_ack before timeout (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request for address pc
imem_ack  in  1  instruction data valid for current request
ir_load  out  1  load instruction register (= FETCH & imem_ack, combinational)
exec_done  in  1  datapath finished current instruction; qualifies halt/jump/br_* inputs
halt  in  1  stop sequencing (sampled with exec_done)
jump  in  1  absolute jump (sampled with exec_done)
jump_index  in  26  MIPS-style jump target index
br_taken  in  1  conditional branch taken (sampled with exec_done)
br_offset  in  32  signed word offset relative to pc+4
pc  out  32  current program counter
state  out  2  RESET=0, FETCH=1, EXEC=2, HALTED=3
retired  out  32  count of completed instructions
timeout  out  1  sticky: a fetch timeout has occurred

Behaviour:
- Reset (rst_n low, asynchronous, at any time, including mid-fetch):
  - pc=RESET_VECTOR, state=RESET, wait counter=0, retired=0, timeout=0.
  - imem_req=0, ir_load=0.
- RESET -> FETCH on the first rising edge after rst_n deasserts.
- FETCH:
  - imem_req=1.
  - imem_ack=1 -> ir_load=1 in the same cycle; next state EXEC; wait counter cleared.
  - imem_ack=0 -> wait counter increments.
  - Counter at MAX_WAIT-1 with no ack -> pc=EXEC_VECTOR... specifically pc=EXC_VECTOR, timeout=1, counter=0, state stays FETCH (refetch from the vector).
  - Ack in the threshold cycle wins over timeout.
- EXEC:
  - imem_req=0. Hold until exec_done=1.
  - On the exec_done edge, priority is halt > jump > br_taken > sequential:
    - halt: pc unchanged, retired unchanged, state -> HALTED.
    - jump: pc={pc4[31:28], jump_index, 2'b00}, retired+1, -> FETCH.
    - br_taken: pc=pc4+(br_offset<<2), truncated to 32 bits, retired+1, -> FETCH.
    - else: pc=pc4, retired+1, -> FETCH.
  - pc4 = pc+4, modulo 2^32.
- HALTED: terminal until reset. imem_req=0; all inputs ignored.
- imem_ack outside FETCH and exec_done outside EXEC are ignored.
- Arithmetic:
  - 32-bit wrap-around: 0xFFFF_FFFC+4 = 0.
  - Negative offsets are two's complement.
  - retired wraps 0xFFFF_FFFF -> 0.
- Minimum throughput: 2 cycles per instruction (ack in the first FETCH cycle, exec_done in the first EXEC cycle).
- pc, state, retired and timeout are registered outputs; only ir_load and imem_req are decoded from state.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state encoding constants (RESET/FETCH/EXEC/HALTED, 2 bits);
  - next-PC select codes (SEQ, BRANCH, JUMP, HOLD, EXC);
  - default RESET_VECTOR and EXC_VECTOR.
- One combinational sub-module, pc_next_calc, takes pc, select code, br_offset, jump_index and EXC_VECTOR and produces next pc. It is reused by the later pipelined core.
- pc_sequencer keeps the FSM, wait counter, retired counter and sticky flag.

Test Plan:
- Reset release, imem_ack tied 1, exec_done tied 1, no branch -> pc goes 0,4,8,12 every 2 cycles; retired=3 after third exec_done.
- pc=0x100, br_taken=1, br_offset=0xFFFF_FFFE (-2) -> pc=0x0FC; br_offset=3 -> pc=0x110.
- pc=0x3000_0010, jump=1, jump_index=0x0000040, br_taken=1 simultaneously -> pc=0x3000_0100 (jump wins).
- imem_ack held 0 in FETCH for 15 cycles (MAX_WAIT=15) -> pc=0x80, timeout=1, imem_req stays 1; ack on the 15th cycle instead -> no timeout, state=EXEC.
- halt=1 with jump=1 at exec_done, pc=0x40 -> state=HALTED, pc=0x40, retired unchanged; later exec_done/imem_ack pulses have no effect.
- rst_n pulled low mid-FETCH-wait (counter=7) -> immediate pc=0, state=RESET, counter=0; pc=0xFFFF_FFFC sequential -> pc=0.
